// File: rtl/bytewrite_ram_arbiter_pkg.sv
// rtl/bytewrite_ram_arbiter_pkg.sv - shared types, widths and helpers for the byte-write RAM arbiter
package bwram_arb_pkg;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   localparam int COL_WIDTH_DEF = 8;
   localparam int NB_COL_DEF    = 4;
   localparam int W_DEF         = COL_WIDTH_DEF * NB_COL_DEF;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/bytewrite_ram_arbiter_if.sv
// rtl/bytewrite_ram_arbiter_if.sv - requester-side request/response bus of the byte-write RAM arbiter
interface bytewrite_ram_arbiter_if
   import bwram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int NB_COL     = NB_COL_DEF,
   parameter int W          = W_DEF
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*NB_COL-1:0]     req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*W-1:0]          req_wdata;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic                          rsp_err;
   logic [W-1:0]                  rsp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_data
   );

endinterface

// File: rtl/bytewrite_ram_arbiter_pick.sv
// rtl/bytewrite_ram_arbiter_pick.sv - rotating first-set picker: request vector + start index -> one-hot grant
module bwram_arb_pick
   import bwram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_start,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   int   w_idx;
   logic w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = int'(i_start) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (!w_found && i_req[w_idx[IDX_W-1:0]]) begin
            w_found                    = 1'b1;
            o_grant[w_idx[IDX_W-1:0]] = 1'b1;
            o_idx                      = w_idx[IDX_W-1:0];
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/bytewrite_ram_arbiter.sv
// rtl/bytewrite_ram_arbiter.sv - zero-fills a shared byte-write BRAM, then grants one access per cycle
// BWRAM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module bytewrite_ram_arbiter
   import bwram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int SIZE       = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int COL_WIDTH  = COL_WIDTH_DEF,
   parameter int NB_COL     = NB_COL_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   bytewrite_ram_arbiter_if.slave        bus,
   output logic                          init_done,
   output logic [NB_COL-1:0]             ram_we,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   output logic [NB_COL*COL_WIDTH-1:0]   ram_di,
   input  logic [NB_COL*COL_WIDTH-1:0]   ram_do
);

   localparam int W     = NB_COL * COL_WIDTH;
   localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
   logic                    r_init_done;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic                    r_rsp_err;

   logic                    w_run;
   logic [NUM_REQ-1:0]      w_req;
   logic [NUM_REQ-1:0]      w_grant;
   logic [IDX_W-1:0]        w_gidx;
   logic [IDX_W-1:0]        w_start;
   logic                    w_any;
   logic [NB_COL-1:0]       w_sel_we;
   logic [ADDR_WIDTH-1:0]   w_sel_addr;
   logic [W-1:0]            w_sel_wdata;
   logic                    w_oob;

   assign w_run = (r_state == ST_RUN);
   assign w_req = bus.req_valid & {NUM_REQ{w_run}};

   bwram_arb_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_req   (w_req),
      .i_start (w_start),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

`ifdef BWRAM_ARB_RR_EN
   logic [IDX_W-1:0] r_rr_ptr;

   // Pointer moves just past the winner so the winner becomes lowest priority next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_any) begin
         r_rr_ptr <= (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
      end
   end

   assign w_start = r_rr_ptr;
`else
   assign w_start = '0;
`endif

   assign w_sel_we    = bus.req_we[w_gidx*NB_COL +: NB_COL];
   assign w_sel_addr  = bus.req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel_wdata = bus.req_wdata[w_gidx*W +: W];
   assign w_oob       = (32'(w_sel_addr) >= 32'(SIZE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The clear sweep is gated by rst_n so the RAM sees no writes while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      ram_we      = '0;
      ram_addr    = '0;
      ram_di      = '0;
      case (r_state)
         ST_INIT: begin
            if (rst_n) begin
               ram_we   = '1;
               ram_addr = r_cnt;
            end
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == ADDR_WIDTH'(SIZE - 1)) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (w_any) begin
               ram_we   = w_oob ? '0 : w_sel_we;
               ram_addr = w_sel_addr;
               ram_di   = w_sel_wdata;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_init_done <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_init_done <= (w_state_nxt == ST_RUN);
         r_rsp_valid <= w_grant;
         r_rsp_err   <= w_any & w_oob;
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_data  = (|r_rsp_valid && !r_rsp_err) ? ram_do : '0;
   assign init_done     = r_init_done;

endmodule

// File: tb/tb_bytewrite_ram_arbiter.sv
// tb/tb_bytewrite_ram_arbiter.sv - self-checking bench for bytewrite_ram_arbiter with a behavioural RAM and reference model
module tb_bytewrite_ram_arbiter;
   import bwram_arb_pkg::*;

   localparam int N    = 2;
   localparam int SIZE = 32;
   localparam int AW   = 10;
   localparam int NBC  = 4;
   localparam int W    = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           init_done;
   logic [NBC-1:0] ram_we;
   logic [AW-1:0]  ram_addr;
   logic [W-1:0]   ram_di;
   logic [W-1:0]   ram_do;

   bytewrite_ram_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .NB_COL(NBC), .W(W)) bus ();

   bytewrite_ram_arbiter #(
      .NUM_REQ(N), .SIZE(SIZE), .ADDR_WIDTH(AW), .COL_WIDTH(8), .NB_COL(NBC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .init_done (init_done),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_di    (ram_di),
      .ram_do    (ram_do)
   );

   // Read-first byte-write RAM macro
   logic [W-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      ram_do <= mem[ram_addr];
      for (int b = 0; b < NBC; b++)
         if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
   end

   int errors = 0;
   int checks = 0;

   logic           p_valid [N];
   logic [NBC-1:0] p_we    [N];
   logic [AW-1:0]  p_addr  [N];
   logic [W-1:0]   p_data  [N];
   logic [W-1:0]   ref_mem [SIZE];
   logic [W-1:0]   rsp_of  [N];
   logic [N-1:0]   exp_rv;
   logic           exp_err;
   logic [W-1:0]   exp_data;
   logic [N-1:0]   last_ready, last_rv;
   logic           last_err;
   logic [W-1:0]   last_data;
   logic [N-1:0]   seq [6];
   int             rr_ptr;
   int             cyc;
   bit             rand_mode;
   bit             hold_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]             = p_valid[i];
         bus.req_we[i*NBC +: NBC]     = p_we[i];
         bus.req_addr[i*AW +: AW]     = p_addr[i];
         bus.req_wdata[i*W +: W]      = p_data[i];
      end
   endtask

   task automatic model_reset();
      cyc      = 0;
      rr_ptr   = 0;
      exp_rv   = '0;
      exp_err  = 1'b0;
      exp_data = '0;
      for (int a = 0; a < SIZE; a++) ref_mem[a] = '0;
   endtask

   task automatic cycle();
      int g;
      int idx;
      int a;
      bit oob;
      g   = -1;
      oob = 1'b0;
      @(negedge clk);
      last_ready = bus.req_ready;
      last_rv    = bus.rsp_valid;
      last_err   = bus.rsp_err;
      last_data  = bus.rsp_data;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      chk("rsp_data", bus.rsp_data, exp_data);
      for (int i = 0; i < N; i++) if (exp_rv[i]) rsp_of[i] = bus.rsp_data;
      if (cyc < SIZE) begin
         chk("init_we", 32'(ram_we), 32'hF);
         chk("init_addr", 32'(ram_addr), 32'(cyc));
         chk("init_di", ram_di, 32'h0);
         chk("init_ready", 32'(bus.req_ready), 32'h0);
         chk("init_done_lo", 32'(init_done), 32'h0);
      end else begin
         chk("init_done_hi", 32'(init_done), 32'h1);
         for (int k = 0; k < N; k++) begin
`ifdef BWRAM_ARB_RR_EN
            idx = (rr_ptr + k) % N;
`else
            idx = k;
`endif
            if (g < 0 && p_valid[idx]) g = idx;
         end
         chk("ready", 32'(bus.req_ready), (g < 0) ? 32'h0 : 32'(1 << g));
         if (g < 0) begin
            chk("idle_we", 32'(ram_we), 32'h0);
         end else begin
            a   = int'(p_addr[g]);
            oob = (a >= SIZE);
            chk("ram_we", 32'(ram_we), oob ? 32'h0 : 32'(p_we[g]));
            chk("ram_addr", 32'(ram_addr), 32'(p_addr[g]));
            if (!oob) chk("ram_di", ram_di, p_data[g]);
         end
      end
      exp_rv   = '0;
      exp_err  = 1'b0;
      exp_data = '0;
      if (g >= 0) begin
         exp_rv[g] = 1'b1;
         if (oob) begin
            exp_err = 1'b1;
         end else begin
            exp_data = ref_mem[a];
            for (int b = 0; b < NBC; b++)
               if (p_we[g][b]) ref_mem[a][b*8 +: 8] = p_data[g][b*8 +: 8];
         end
         rr_ptr     = (g + 1) % N;
         p_valid[g] = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rand_mode) begin
         for (int i = 0; i < N; i++) begin
            if (!p_valid[i] && $urandom_range(0, 9) < 7) begin
               p_valid[i] = 1'b1;
               p_we[i]    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
               p_addr[i]  = 10'($urandom_range(0, 47));
               p_data[i]  = $urandom;
            end
         end
      end
      if (hold_mode && g >= 0) p_valid[g] = 1'b1;
      drive();
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
      chk("rst_rsp_data", bus.rsp_data, 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);
      chk("rst_ram_we", 32'(ram_we), 32'h0);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_di", ram_di, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic issue(input int id, input logic [3:0] we, input logic [9:0] addr, input logic [31:0] data);
      int n;
      n           = 0;
      p_valid[id] = 1'b1;
      p_we[id]    = we;
      p_addr[id]  = addr;
      p_data[id]  = data;
      drive();
      while (p_valid[id] && n < 20) begin
         cycle();
         n++;
      end
      chk("issue_granted", 32'(p_valid[id]), 32'h0);
      cycle();
   endtask

   initial begin
      rand_mode = 1'b0;
      hold_mode = 1'b0;
      for (int i = 0; i < N; i++) begin
         p_valid[i] = 1'b0;
         p_we[i]    = '0;
         p_addr[i]  = '0;
         p_data[i]  = '0;
         rsp_of[i]  = '0;
      end
      drive();
      model_reset();
      @(posedge clk);
      #1;
      reset_pulse();

      // Sweep with both requesters waiting; no ready may appear until init finishes.
      p_valid[0] = 1'b1; p_addr[0] = 10'd0;
      p_valid[1] = 1'b1; p_addr[1] = 10'd1;
      drive();
      repeat (SIZE) cycle();
      repeat (3) cycle();

      issue(0, 4'b0101, 10'd5, 32'hAABBCCDD);
      chk("t2_write_old", rsp_of[0], 32'h0);
      issue(0, 4'b0000, 10'd5, 32'h0);
      chk("t2_read_merged", rsp_of[0], 32'h00BB00DD);

      p_valid[0] = 1'b1; p_we[0] = '0; p_addr[0] = 10'd1;
      p_valid[1] = 1'b1; p_we[1] = '0; p_addr[1] = 10'd2;
      hold_mode  = 1'b1;
      drive();
      for (int k = 0; k < 6; k++) begin
         cycle();
         seq[k] = last_ready;
      end
      hold_mode  = 1'b0;
      p_valid[0] = 1'b0;
      p_valid[1] = 1'b0;
      drive();
      repeat (2) cycle();
      for (int k = 0; k < 5; k++) begin
`ifdef BWRAM_ARB_RR_EN
         chk("t3_alternate", 32'(seq[k+1]), (seq[k] == 2'b01) ? 32'h2 : 32'h1);
`else
         chk("t3_fixed_prio", 32'(seq[k+1]), 32'h1);
`endif
      end

      issue(1, 4'b0000, 10'd40, 32'h0);
      chk("t4_rsp_valid", 32'(last_rv), 32'h2);
      chk("t4_rsp_err", 32'(last_err), 32'h1);
      chk("t4_rsp_data", last_data, 32'h0);

      rsp_of[1]  = '0;
      p_valid[0] = 1'b1; p_we[0] = 4'hF; p_addr[0] = 10'd3; p_data[0] = 32'h12345678;
      p_valid[1] = 1'b1; p_we[1] = 4'h0; p_addr[1] = 10'd3; p_data[1] = 32'h0;
      drive();
      repeat (3) cycle();
      chk("t6_read_after_write", rsp_of[1], 32'h12345678);

      rand_mode = 1'b1;
      repeat (150) cycle();
      reset_pulse();
      repeat (10) cycle();
      reset_pulse();
      repeat (SIZE + 200) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
